tile2_seq_mult: RTL and testbench
=================================

Name: tile2_seq_mult

Overview:
Parametrised iterative multiplier that decomposes WIDTH x WIDTH operands into 2-bit digits and evaluates the 2x2 digit-pair partial products sequentially, TILES_PER_CYCLE per clock, accumulating with shifts. It generalises the fixed four-tile 4-bit combinational composition to arbitrary even widths, adds optional two's-complement mode, and wraps the datapath in valid/ready handshakes. It serves as the area-reduced multiplier slot in wider datapaths.

Parameters:
WIDTH, 8, operand width; even, >= 4
TILES_PER_CYCLE, 1, 2x2 tiles evaluated per clock; must divide (WIDTH/2)^2

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = a, b two's complement; 0 = unsigned; sampled with operands
out_valid  output  1  out_p holds a completed product
out_ready  input  1  consumer accepts out_p
out_p  output  2*WIDTH  product (two's complement when signed_mode was 1)
busy  output  1  high in BUSY state

Behaviour:
- Single clock, synchronous active-high reset; all state changes on rising clk.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, accumulator=0, tile counter=0. Reset mid-operation aborts immediately; partial result discarded, no out_valid.
- Definitions: D=WIDTH/2 digits; T=D*D tiles; C=T/TILES_PER_CYCLE compute cycles. Tile k (0..T-1): i=k mod D, j=k div D; tile product = exact 4-bit product of magnitude digits A[2i+1:2i] x B[2j+1:2j], shifted left by 2*(i+j). Tiles within one cycle use consecutive k.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid=1 the operands are accepted: latch signed_mode; if signed_mode=1, latch |a|, |b| as WIDTH-bit unsigned magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1), no overflow) and neg = sign(a) XOR sign(b); otherwise latch a, b raw, neg=0. Clear accumulator and counter; go to BUSY.
- BUSY: in_ready=0, busy=1. Each cycle, add TILES_PER_CYCLE tile products to the 2*WIDTH-bit accumulator (no overflow possible) and advance the counter. On the C-th BUSY edge, load out_p = neg ? -(final sum) : final sum (2*WIDTH bits, modulo 2^(2*WIDTH)); go to DONE.
- Latency: operands accepted at edge E0 -> out_valid=1 after edge E0+C (WIDTH=8, TPC=1: 16 cycles).
- DONE: out_valid=1, in_ready=0, out_p held stable. On out_ready=1, go to IDLE (out_valid=0 after that edge); out_p retains its last value. No accept in the handoff cycle; next accept earliest one cycle later.
- in_valid or input changes during BUSY/DONE are ignored. out_ready outside DONE is ignored.
- Zero operands take the full C cycles (no early termination).

Test Plan:
- Unsigned max: WIDTH=8, TPC=1, signed_mode=0, a=255, b=255 -> out_valid after exactly 16 edges post-accept, out_p=0xFE01; busy high for those 16 cycles.
- Signed corners: signed_mode=1, a=0x80, b=0x80 -> out_p=0x4000; a=0xFF, b=0x7F -> out_p=0xFF81; a=0x00, b=0x80 -> out_p=0x0000.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, out_p stable, in_ready stays 0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst at BUSY cycle 7 -> following cycle out_valid=0, in_ready=1, out_p=0; subsequent 3x5 returns 0x000F with normal latency.
- Parametric: WIDTH=8, TPC=4 -> 200x123 = 0x6018 after 4 cycles; WIDTH=16, TPC=1 -> 65535x65535 = 0xFFFE0001 after 64 cycles.
- Random: 10k random operands/modes with random out_ready stalls for WIDTH in {4,8,12} -> all results match a reference model, none lost or duplicated.

Source files
------------

// File: rtl/tile2_seq_mult.sv
// Purpose: iterative WIDTH x WIDTH multiplier built from 2x2-bit digit tiles, TILES_PER_CYCLE tiles per clock, optional signed mode.
// Latency: (WIDTH/2)^2 / TILES_PER_CYCLE cycles from operand accept to out_valid.
// Backpressure: result is held in DONE until out_ready; in_ready is low in BUSY and DONE.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a, b, signed_mode operand handshake;
//        out_valid/out_ready + out_p (2*WIDTH) result handshake; busy is high while tiles are being summed.
module tile2_seq_mult #(
    parameter int WIDTH           = 8,
    parameter int TILES_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int D  = WIDTH / 2;
    localparam int T  = D * D;
    localparam int C  = T / TILES_PER_CYCLE;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    // Digit index must also hold i+j, which reaches 2*(D-1).
    localparam int DW = $clog2(D) + 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [DW-1:0] D_LAST = DW'(D - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     cyc_cnt;
    // Tile position (i over a digits, j over b digits) of the first tile this cycle.
    logic [DW-1:0]     i_cnt;
    logic [DW-1:0]     j_cnt;

    // Magnitudes of the incoming operands; two's complement negation of the
    // most negative value yields 2^(WIDTH-1), which is the correct magnitude.
    logic [WIDTH-1:0]  a_abs;
    logic [WIDTH-1:0]  b_abs;
    logic              a_negative;
    logic              b_negative;

    assign a_negative = signed_mode & a[WIDTH-1];
    assign b_negative = signed_mode & b[WIDTH-1];
    assign a_abs      = a_negative ? (~a + 1'b1) : a;
    assign b_abs      = b_negative ? (~b + 1'b1) : b;

    // Sum of this cycle's tiles. Tiles walk k = i + j*D, so i wraps into j.
    logic [PW-1:0]     tile_sum;
    logic [DW-1:0]     i_nxt;
    logic [DW-1:0]     j_nxt;
    logic [1:0]        da;
    logic [1:0]        db;
    logic [3:0]        prod;

    always_comb begin
        tile_sum = '0;
        i_nxt    = i_cnt;
        j_nxt    = j_cnt;
        da       = '0;
        db       = '0;
        prod     = '0;
        for (int t = 0; t < TILES_PER_CYCLE; t++) begin
            da       = 2'(a_mag >> {i_nxt, 1'b0});
            db       = 2'(b_mag >> {j_nxt, 1'b0});
            prod     = {2'b00, da} * {2'b00, db};
            tile_sum = tile_sum + ({{(PW-4){1'b0}}, prod} << {(i_nxt + j_nxt), 1'b0});
            if (i_nxt == D_LAST) begin
                i_nxt = '0;
                j_nxt = j_nxt + 1'b1;
            end else begin
                i_nxt = i_nxt + 1'b1;
            end
        end
    end

    logic [PW-1:0] final_sum;
    assign final_sum = acc + tile_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_mag   <= '0;
            b_mag   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cyc_cnt <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            out_p   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        neg     <= a_negative ^ b_negative;
                        acc     <= '0;
                        cyc_cnt <= '0;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc     <= final_sum;
                    cyc_cnt <= cyc_cnt + 1'b1;
                    i_cnt   <= i_nxt;
                    j_cnt   <= j_nxt;
                    if (cyc_cnt == C_LAST) begin
                        out_p <= neg ? (~final_sum + 1'b1) : final_sum;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_tile2_seq_mult.sv
module tb_tile2_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Main instance: WIDTH=8, TPC=1
    logic        iv0 = 0, sm0 = 0, ordy0 = 0;
    logic [7:0]  a0 = 0, b0 = 0;
    logic        ir0, ov0, bz0;
    logic [15:0] p0;
    tile2_seq_mult #(.WIDTH(8), .TILES_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .signed_mode(sm0), .out_valid(ov0), .out_ready(ordy0), .out_p(p0), .busy(bz0));

    // WIDTH=8, TPC=4
    logic        iv1 = 0, ordy1 = 0;
    logic [7:0]  a1 = 0, b1 = 0;
    logic        ir1, ov1, bz1;
    logic [15:0] p1;
    tile2_seq_mult #(.WIDTH(8), .TILES_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .signed_mode(1'b0), .out_valid(ov1), .out_ready(ordy1), .out_p(p1), .busy(bz1));

    // WIDTH=16, TPC=1
    logic        iv2 = 0, ordy2 = 0;
    logic [15:0] a2 = 0, b2 = 0;
    logic        ir2, ov2, bz2;
    logic [31:0] p2;
    tile2_seq_mult #(.WIDTH(16), .TILES_PER_CYCLE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .signed_mode(1'b0), .out_valid(ov2), .out_ready(ordy2), .out_p(p2), .busy(bz2));

    // Present one operand pair to dut0, return cycles until out_valid and busy-cycle count.
    task automatic run0(input logic [7:0] x, input logic [7:0] y, input logic s,
                        output int lat, output int bcnt);
        @(negedge clk);
        a0 = x; b0 = y; sm0 = s; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        lat = 0; bcnt = 0;
        while (!ov0 && lat < 200) begin
            if (bz0) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release0();
        @(negedge clk);
        ordy0 = 1'b1;
        @(posedge clk); #1;
        ordy0 = 1'b0;
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy;
        if (s) begin
            sx = $signed({{8{x[7]}}, x});
            sy = $signed({{8{y[7]}}, y});
            return 16'(sx * sy);
        end
        return {8'b0, x} * {8'b0, y};
    endfunction

    initial begin
        int lat, bcnt, n;
        logic [15:0] held;
        logic [7:0]  rx, ry;
        logic        rs;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ir0, 1'b1);
        check("rst_out_valid", ov0, 1'b0);
        check("rst_busy", bz0, 1'b0);
        check("rst_out_p", p0, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned max
        run0(8'hFF, 8'hFF, 1'b0, lat, bcnt);
        check("umax_latency", lat, 16);
        check("umax_busy_cycles", bcnt, 16);
        check("umax_p", p0, 16'hFE01);
        check("umax_in_ready_done", ir0, 1'b0);
        release0();
        check("umax_release_ov", ov0, 1'b0);
        check("umax_release_ir", ir0, 1'b1);
        check("umax_p_retained", p0, 16'hFE01);

        // Signed corners
        run0(8'h80, 8'h80, 1'b1, lat, bcnt);
        check("s_80x80", p0, 16'h4000);
        release0();
        run0(8'hFF, 8'h7F, 1'b1, lat, bcnt);
        check("s_ffx7f", p0, 16'hFF81);
        release0();
        run0(8'h00, 8'h80, 1'b1, lat, bcnt);
        check("s_00x80", p0, 16'h0000);
        check("s_zero_latency", lat, 16);
        release0();
        run0(8'hFD, 8'h05, 1'b1, lat, bcnt);
        check("s_m3x5", p0, 16'hFFF1);
        release0();
        run0(8'hFD, 8'h05, 1'b0, lat, bcnt);
        check("u_253x5", p0, 16'h04F1);
        release0();

        // Backpressure in DONE, new operands offered must be ignored
        run0(8'd12, 8'd11, 1'b0, lat, bcnt);
        check("bp_p", p0, 16'd132);
        held = p0;
        @(negedge clk);
        iv0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_ov_held", ov0, 1'b1);
            check("bp_p_stable", p0, held);
            check("bp_ir_low", ir0, 1'b0);
        end
        @(negedge clk);
        iv0 = 1'b0;
        release0();
        check("bp_idle_ir", ir0, 1'b1);
        check("bp_idle_busy", bz0, 1'b0);

        // Reset at BUSY cycle 7
        @(negedge clk);
        a0 = 8'd200; b0 = 8'd200; sm0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ov", ov0, 1'b0);
        check("mid_rst_ir", ir0, 1'b1);
        check("mid_rst_p", p0, 16'h0);
        check("mid_rst_busy", bz0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run0(8'd3, 8'd5, 1'b0, lat, bcnt);
        check("post_rst_latency", lat, 16);
        check("post_rst_p", p0, 16'h000F);
        release0();

        // WIDTH=8, TPC=4
        @(negedge clk);
        a1 = 8'd200; b1 = 8'd123; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 200) begin @(posedge clk); #1; n++; end
        check("tpc4_latency", n, 4);
        check("tpc4_p", p1, 16'h6018);

        // WIDTH=16, TPC=1
        @(negedge clk);
        a2 = 16'hFFFF; b2 = 16'hFFFF; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        n = 0;
        while (!ov2 && n < 200) begin @(posedge clk); #1; n++; end
        check("w16_latency", n, 64);
        check("w16_p", p2, 32'hFFFE0001);

        // Random operands/modes with random consumer stalls
        for (int r = 0; r < 40; r++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rs = 1'($urandom);
            run0(rx, ry, rs, lat, bcnt);
            check("rnd_latency", lat, 16);
            check("rnd_p", p0, ref8(rx, ry, rs));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rnd_stall_ov", ov0, 1'b1);
            release0();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
